// File: rtl/traffic_phase_controller_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the N-phase traffic signal controller:
//   - state_t      : interval state encoding (GREEN / YELLOW / ALLRED)
//   - DEF_*        : default timing / sizing constants
//   - rr_index     : round-robin phase index helper used by the arbiter
// -----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'b00,
        ST_YELLOW = 2'b01,
        ST_ALLRED = 2'b10
    } state_t;

    localparam int DEF_NUM_PHASES  = 4;
    localparam int DEF_TIMER_W     = 8;
    localparam int DEF_MIN_GREEN   = 5;
    localparam int DEF_MAX_GREEN   = 20;
    localparam int DEF_YELLOW_TIME = 3;
    localparam int DEF_ALLRED_TIME = 2;

    // Phase reached by stepping 'step' positions forward from 'base',
    // wrapping at 'n' phases (n need not be a power of two).
    function automatic int rr_index(input int base, input int step, input int n);
        return (base + step) % n;
    endfunction

endpackage

// File: rtl/traffic_phase_controller_arbiter.sv
// -----------------------------------------------------------------------------
// traffic_phase_arbiter
// Combinational round-robin next-phase selector.
//   demand           in  NUM_PHASES  per-phase request levels
//   active_phase     in  PH_W        phase currently owning the sequence
//   next_phase       out PH_W        first requesting phase after active_phase
//                                    (wrapping, active_phase checked last);
//                                    active_phase+1 when nothing requests
//   any_other_demand out 1           some phase other than active_phase requests
// -----------------------------------------------------------------------------
module traffic_phase_arbiter
    import traffic_pkg::*;
#(
    parameter  int NUM_PHASES = DEF_NUM_PHASES,
    localparam int PH_W       = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic [NUM_PHASES-1:0] demand,
    input  logic [PH_W-1:0]       active_phase,
    output logic [PH_W-1:0]       next_phase,
    output logic                  any_other_demand
);

    logic [NUM_PHASES-1:0] other_mask;
    int                    idx;

    always_comb begin
        other_mask               = demand;
        other_mask[active_phase] = 1'b0;
        any_other_demand         = |other_mask;
    end

    // Walk the distances from farthest to nearest so the nearest requesting
    // phase is written last and wins. Distance 0 (the active phase itself)
    // is the lowest priority, so it is considered before the loop.
    always_comb begin
        idx = 0;
        if (active_phase == PH_W'(NUM_PHASES - 1))
            next_phase = '0;
        else
            next_phase = active_phase + 1'b1;
        if (demand[active_phase])
            next_phase = active_phase;
        for (int k = NUM_PHASES - 1; k >= 1; k--) begin
            idx = rr_index(int'(active_phase), k, NUM_PHASES);
            if (demand[idx[PH_W-1:0]])
                next_phase = idx[PH_W-1:0];
        end
    end

endmodule

// File: rtl/traffic_phase_controller.sv
// -----------------------------------------------------------------------------
// traffic_phase_controller
// N-phase actuated traffic signal controller. Sequences mutually conflicting
// phases through GREEN -> YELLOW -> ALLRED, skipping unrequested phases and
// bounding green time between MIN_GREEN and MAX_GREEN ticks. All state moves
// only on CLK edges where TICK=1.
//
// Optional build macro: PREEMPT_EN adds emergency preemption
// (PREEMPT / PREEMPT_PHASE ports). Without it the controller behaves as if
// PREEMPT were held at 0.
//
// Ports:
//   CLK, RESET_N (async, active-low), TICK (timebase enable)
//   DEMAND[NUM_PHASES]          per-phase request levels
//   PREEMPT, PREEMPT_PHASE      emergency request / phase to serve (PREEMPT_EN)
//   GREEN/YELLOW/RED[NUM_PHASES] lamp drives, decoded from registers
//   active_phase, state, timer  registered sequencing state
// -----------------------------------------------------------------------------
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter  int NUM_PHASES  = DEF_NUM_PHASES,
    parameter  int TIMER_W     = DEF_TIMER_W,
    parameter  int MIN_GREEN   = DEF_MIN_GREEN,
    parameter  int MAX_GREEN   = DEF_MAX_GREEN,
    parameter  int YELLOW_TIME = DEF_YELLOW_TIME,
    parameter  int ALLRED_TIME = DEF_ALLRED_TIME,
    localparam int PH_W        = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  TICK,
    input  logic [NUM_PHASES-1:0] DEMAND,
`ifdef PREEMPT_EN
    input  logic                  PREEMPT,
    input  logic [PH_W-1:0]       PREEMPT_PHASE,
`endif
    output logic [NUM_PHASES-1:0] GREEN,
    output logic [NUM_PHASES-1:0] YELLOW,
    output logic [NUM_PHASES-1:0] RED,
    output logic [PH_W-1:0]       active_phase,
    output logic [1:0]            state,
    output logic [TIMER_W-1:0]    timer
);

    // Last timer value of each interval (interval of length L runs 0..L-1).
    localparam logic [TIMER_W-1:0] MIN_LAST = TIMER_W'(MIN_GREEN - 1);
    localparam logic [TIMER_W-1:0] MAX_LAST = TIMER_W'(MAX_GREEN - 1);
    localparam logic [TIMER_W-1:0] YEL_LAST = TIMER_W'(YELLOW_TIME - 1);
    localparam logic [TIMER_W-1:0] AR_LAST  = TIMER_W'(ALLRED_TIME - 1);

    state_t              st_q, st_d;
    logic [PH_W-1:0]     ph_q, ph_d;
    logic [TIMER_W-1:0]  tmr_q, tmr_d;

    logic                preempt;
    logic [PH_W-1:0]     preempt_phase;
    logic                preempt_hold;
    logic                preempt_cut;
    logic                green_exit;
    logic [PH_W-1:0]     arb_next;
    logic                any_other;

`ifdef PREEMPT_EN
    // PREEMPT_PHASE must name an existing phase; it is used as-is.
    assign preempt       = PREEMPT;
    assign preempt_phase = PREEMPT_PHASE;
`else
    assign preempt       = 1'b0;
    assign preempt_phase = '0;
`endif

    traffic_phase_arbiter #(
        .NUM_PHASES (NUM_PHASES)
    ) u_arb (
        .demand           (DEMAND),
        .active_phase     (ph_q),
        .next_phase       (arb_next),
        .any_other_demand (any_other)
    );

    // Preemption for the phase already green just pins it there; for any
    // other phase it cuts green short, ignoring MIN_GREEN.
    assign preempt_hold = preempt && (preempt_phase == ph_q);
    assign preempt_cut  = preempt && (preempt_phase != ph_q);

    assign green_exit = preempt_cut ||
                        (!preempt && (tmr_q >= MIN_LAST) && any_other &&
                         (!DEMAND[ph_q] || (tmr_q == MAX_LAST)));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            st_q  <= ST_GREEN;
            ph_q  <= '0;
            tmr_q <= '0;
        end else if (TICK) begin
            st_q  <= st_d;
            ph_q  <= ph_d;
            tmr_q <= tmr_d;
        end
    end

    always_comb begin
        st_d  = st_q;
        ph_d  = ph_q;
        tmr_d = tmr_q + 1'b1;
        unique case (st_q)
            ST_GREEN: begin
                if (green_exit) begin
                    st_d  = ST_YELLOW;
                    tmr_d = '0;
                end else if (tmr_q == MAX_LAST || preempt_hold && tmr_q >= MAX_LAST) begin
                    // Resting green: hold at the max-green mark so a later
                    // demand can exit as soon as it is seen.
                    tmr_d = tmr_q;
                end
            end
            ST_YELLOW: begin
                if (tmr_q == YEL_LAST) begin
                    st_d  = ST_ALLRED;
                    tmr_d = '0;
                end
            end
            ST_ALLRED: begin
                if (tmr_q == AR_LAST) begin
                    st_d  = ST_GREEN;
                    tmr_d = '0;
                    ph_d  = preempt ? preempt_phase : arb_next;
                end
            end
            default: begin
                // Unused encoding: recover to a safe green on the same phase.
                st_d  = ST_GREEN;
                tmr_d = '0;
            end
        endcase
    end

    // One lamp colour per phase; only the active phase can be non-red.
    for (genvar p = 0; p < NUM_PHASES; p++) begin : g_lamp
        assign GREEN[p]  = (st_q == ST_GREEN)  && (ph_q == PH_W'(p));
        assign YELLOW[p] = (st_q == ST_YELLOW) && (ph_q == PH_W'(p));
        assign RED[p]    = !(GREEN[p] || YELLOW[p]);
    end

    assign active_phase = ph_q;
    assign state        = st_q;
    assign timer        = tmr_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
module tb_traffic_phase_controller;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       TICK;
    logic [3:0] DEMAND;
`ifdef PREEMPT_EN
    logic       PREEMPT;
    logic [1:0] PREEMPT_PHASE;
`endif
    logic [3:0] GREEN, YELLOW, RED;
    logic [1:0] active_phase;
    logic [1:0] state;
    logic [7:0] timer;

    int total = 0;
    int bad   = 0;

    traffic_phase_controller dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .TICK          (TICK),
        .DEMAND        (DEMAND),
`ifdef PREEMPT_EN
        .PREEMPT       (PREEMPT),
        .PREEMPT_PHASE (PREEMPT_PHASE),
`endif
        .GREEN         (GREEN),
        .YELLOW        (YELLOW),
        .RED           (RED),
        .active_phase  (active_phase),
        .state         (state),
        .timer         (timer)
    );

    always #5 CLK = ~CLK;

    // Expected {GREEN,YELLOW,RED} for interval code c (0 green, 1 yellow,
    // 2 all-red) on phase ph.
    function automatic logic [11:0] lamps(input int c, input int ph);
        logic [3:0] g, y;
        g = 4'b0;
        y = 4'b0;
        if (c == 0) g[ph] = 1'b1;
        if (c == 1) y[ph] = 1'b1;
        return {g, y, ~(g | y)};
    endfunction

    // Reset asserted for two cycles, released on a falling edge so the next
    // rising edge is tick 1.
    task automatic do_reset();
        RESET_N = 1'b0;
        TICK    = 1'b1;
        DEMAND  = 4'b0;
`ifdef PREEMPT_EN
        PREEMPT       = 1'b0;
        PREEMPT_PHASE = 2'd0;
`endif
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({GREEN, YELLOW, RED} !== 12'b0001_0000_1110) begin
            bad++;
            $display("FAIL reset_lamps got=%b want=%b", {GREEN, YELLOW, RED}, 12'b0001_0000_1110);
        end
        total++;
        if ({state, active_phase, timer} !== 12'h0) begin
            bad++;
            $display("FAIL reset_regs got st=%0d ph=%0d tmr=%0d want 0/0/0", state, active_phase, timer);
        end
    endtask

    task automatic test_idle();
        do_reset();
        for (int k = 1; k <= 100; k++) begin
            @(negedge CLK);
            total++;
            if ({GREEN, YELLOW, RED} !== 12'b0001_0000_1110) begin
                bad++;
                $display("FAIL idle k=%0d got=%b want=%b", k, {GREEN, YELLOW, RED}, 12'b0001_0000_1110);
            end
        end
        total++;
        if (timer !== 8'd19) begin
            bad++;
            $display("FAIL idle_timer_sat got=%0d want=19", timer);
        end
    endtask

    task automatic test_skip();
        logic [11:0] e;
        do_reset();
        DEMAND = 4'b0100;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if      (k < 5)  e = lamps(0, 0);
            else if (k < 8)  e = lamps(1, 0);
            else if (k < 10) e = lamps(2, 0);
            else             e = lamps(0, 2);
            total++;
            if ({GREEN, YELLOW, RED} !== e) begin
                bad++;
                $display("FAIL skip k=%0d got=%b want=%b", k, {GREEN, YELLOW, RED}, e);
            end
        end
        total++;
        if ({active_phase, state, timer} !== {2'd2, 2'd0, 8'd19}) begin
            bad++;
            $display("FAIL skip_rest got ph=%0d st=%0d tmr=%0d want 2/0/19", active_phase, state, timer);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] e;
        do_reset();
        DEMAND = 4'b0011;
        for (int k = 1; k <= 50; k++) begin
            @(negedge CLK);
            if      (k < 20) e = lamps(0, 0);
            else if (k < 23) e = lamps(1, 0);
            else if (k < 25) e = lamps(2, 0);
            else if (k < 45) e = lamps(0, 1);
            else if (k < 48) e = lamps(1, 1);
            else if (k < 50) e = lamps(2, 1);
            else             e = lamps(0, 0);
            total++;
            if ({GREEN, YELLOW, RED} !== e) begin
                bad++;
                $display("FAIL maxout k=%0d got=%b want=%b", k, {GREEN, YELLOW, RED}, e);
            end
        end
    endtask

    // Demand vanishes during clearance: the controller still advances by one.
    task automatic test_no_demand_advance();
        logic [11:0] e;
        do_reset();
        DEMAND = 4'b0100;
        for (int k = 1; k <= 14; k++) begin
            @(negedge CLK);
            if (k == 5) DEMAND = 4'b0000;
            if      (k < 5)  e = lamps(0, 0);
            else if (k < 8)  e = lamps(1, 0);
            else if (k < 10) e = lamps(2, 0);
            else             e = lamps(0, 1);
            total++;
            if ({GREEN, YELLOW, RED} !== e) begin
                bad++;
                $display("FAIL nodemand k=%0d got=%b want=%b", k, {GREEN, YELLOW, RED}, e);
            end
        end
    endtask

    task automatic test_slow_tick();
        logic [11:0] e, prev;
        int t;
        do_reset();
        DEMAND = 4'b0010;
        prev   = 12'b0001_0000_1110;
        for (int j = 1; j <= 48; j++) begin
            TICK = (j % 4 == 0);
            @(negedge CLK);
            t = j / 4;
            if      (t < 5)  e = lamps(0, 0);
            else if (t < 8)  e = lamps(1, 0);
            else if (t < 10) e = lamps(2, 0);
            else             e = lamps(0, 1);
            total++;
            if ({GREEN, YELLOW, RED} !== e) begin
                bad++;
                $display("FAIL slowtick j=%0d got=%b want=%b", j, {GREEN, YELLOW, RED}, e);
            end
            if (j % 4 != 0) begin
                total++;
                if ({GREEN, YELLOW, RED} !== prev) begin
                    bad++;
                    $display("FAIL slowtick_hold j=%0d got=%b want=%b", j, {GREEN, YELLOW, RED}, prev);
                end
            end
            prev = e;
        end
        TICK = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        DEMAND = 4'b0100;
        repeat (10) @(negedge CLK);
        DEMAND = 4'b0001;
        repeat (6) @(negedge CLK);
        total++;
        if ({state, YELLOW, timer} !== {2'd1, 4'b0100, 8'd1}) begin
            bad++;
            $display("FAIL pre_reset_yellow got st=%0d Y=%b tmr=%0d want 1/0100/1", state, YELLOW, timer);
        end
        RESET_N = 1'b0;
        #1;
        total++;
        if ({GREEN, YELLOW, RED} !== 12'b0001_0000_1110) begin
            bad++;
            $display("FAIL midreset_lamps got=%b want=%b", {GREEN, YELLOW, RED}, 12'b0001_0000_1110);
        end
        total++;
        if ({state, active_phase, timer} !== 12'h0) begin
            bad++;
            $display("FAIL midreset_regs got st=%0d ph=%0d tmr=%0d want 0/0/0", state, active_phase, timer);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

`ifdef PREEMPT_EN
    task automatic test_preempt();
        logic [11:0] e;
        do_reset();
        @(negedge CLK);
        total++;
        if (timer !== 8'd1) begin
            bad++;
            $display("FAIL preempt_start got tmr=%0d want=1", timer);
        end
        PREEMPT       = 1'b1;
        PREEMPT_PHASE = 2'd3;
        DEMAND        = 4'b0111;
        for (int k = 2; k <= 40; k++) begin
            @(negedge CLK);
            if      (k < 5) e = lamps(1, 0);
            else if (k < 7) e = lamps(2, 0);
            else            e = lamps(0, 3);
            total++;
            if ({GREEN, YELLOW, RED} !== e) begin
                bad++;
                $display("FAIL preempt k=%0d got=%b want=%b", k, {GREEN, YELLOW, RED}, e);
            end
        end
        total++;
        if (timer !== 8'd19) begin
            bad++;
            $display("FAIL preempt_sat got tmr=%0d want=19", timer);
        end
        PREEMPT = 1'b0;
        @(negedge CLK);
        total++;
        if ({GREEN, YELLOW, RED} !== lamps(1, 3)) begin
            bad++;
            $display("FAIL preempt_release got=%b want=%b", {GREEN, YELLOW, RED}, lamps(1, 3));
        end
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_skip();
        test_back_to_back();
        test_no_demand_advance();
        test_slow_tick();
        test_reset_mid();
`ifdef PREEMPT_EN
        test_preempt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_phase_controller.md
# traffic_phase_controller

Parametrised N-phase traffic signal controller, the next generation of the fixed 4-way NS/EW controller. It sequences any number of conflicting phases through green, yellow and all-red clearance intervals. Green time is actuated by per-phase demand sensors, with minimum and maximum green limits. Unrequested phases are skipped, and an optional emergency preemption can be compiled in. It sits between the intersection timebase (a 1 Hz tick generator) and the lamp drivers.

## Interface
- NUM_PHASES, 4, number of mutually conflicting phases (2..16); PH_W = $clog2(NUM_PHASES)
- TIMER_W, 8, interval timer width
- MIN_GREEN, 5, minimum green ticks (1..MAX_GREEN)
- MAX_GREEN, 20, maximum green ticks (MIN_GREEN..2^TIMER_W-1)
- YELLOW_TIME, 3, yellow ticks (>=1)
- ALLRED_TIME, 2, all-red clearance ticks (>=1)
- CLK  in  1  system clock
- RESET_N  in  1  reset, asynchronous, active-low
- TICK  in  1  timebase enable; all state/timer updates occur only on CLK edges with TICK=1
- DEMAND  in  NUM_PHASES  per-phase vehicle/pedestrian request, level, synchronous to CLK
- PREEMPT  in  1  emergency preempt request, level (PREEMPT_EN only)
- PREEMPT_PHASE  in  PH_W  phase to serve under preemption (PREEMPT_EN only)
- GREEN, YELLOW, RED  out  NUM_PHASES each  lamp drives, one bit per phase
- active_phase  out  PH_W  phase currently owning green/yellow/all-red sequence
- state  out  2  interval state (GREEN/YELLOW/ALLRED)
- timer  out  TIMER_W  ticks elapsed in current interval

## Operation
- States: ST_GREEN, ST_YELLOW, ST_ALLRED. Registers: state, active_phase, timer.
- Interval of length L: timer counts 0..L-1 on TICKs. Transition on the TICK where timer==L-1, and timer reloads 0.
- GREEN exit condition: timer>=MIN_GREEN-1, AND another phase has DEMAND high, AND (DEMAND[active_phase]==0 OR timer==MAX_GREEN-1).
- No other demand: rest in green; timer saturates at MAX_GREEN-1.
- YELLOW lasts YELLOW_TIME, then ALLRED lasts ALLRED_TIME.
- Exiting ALLRED selects the next phase: first phase with DEMAND set, searching round-robin from active_phase+1 (wrapping; active_phase itself is last).
  - DEMAND sampled at that TICK. If none is set, next = active_phase+1 mod NUM_PHASES.
- Lamp decode from registered state:
  - GREEN: GREEN[active_phase]=1.
  - YELLOW: YELLOW[active_phase]=1.
  - All other phase bits, and all phases in ALLRED: RED=1.
- Invariants:
  - Exactly one of R/Y/G set per phase.
  - At most one phase non-red at any time.
  - Never green to green without YELLOW and ALLRED in between.
- Reset (any time, including mid-interval): state=ST_GREEN, active_phase=0, timer=0 → GREEN=1 on phase 0, RED=all other bits, YELLOW=0.

## Timing
- Outputs are combinational decode of registers. They change only in the cycle after a CLK edge with TICK=1, never on non-TICK cycles.
- Demand-to-lamp latency: DEMAND sampled on TICK edges; the effect is visible one CLK after that edge.
- DEMAND pulses shorter than one TICK period may be missed. Callers latch requests externally.
- Minimum phase cycle: MIN_GREEN+YELLOW_TIME+ALLRED_TIME ticks.

## Configuration
- PREEMPT_EN defined: PREEMPT and PREEMPT_PHASE ports exist; preemption is evaluated on each TICK while PREEMPT=1.
  - In GREEN with active_phase!=PREEMPT_PHASE: go to YELLOW immediately, ignoring MIN_GREEN.
  - In YELLOW or ALLRED: complete normally; ALLRED exit selects PREEMPT_PHASE regardless of DEMAND.
  - In GREEN with active_phase==PREEMPT_PHASE: hold green, timer saturates, other DEMAND ignored.
  - Release: normal GREEN exit rules resume from the current timer value.
- PREEMPT_EN undefined: ports absent; behaviour identical to PREEMPT permanently 0.

## Structure
- Package traffic_pkg:
  - state encoding ST_GREEN=2'b00, ST_YELLOW=2'b01, ST_ALLRED=2'b10
  - default timing constants
  - state typedef
- Sub-module traffic_phase_arbiter: combinational round-robin next-phase selector (inputs DEMAND, active_phase; outputs next phase and any_other_demand flag).

## Test plan
Defaults apply, with TICK=1 every cycle unless stated.
- Reset with DEMAND=0 for 100 ticks -> GREEN=4'b0001, RED=4'b1110 throughout; timer saturates at 19.
- DEMAND=4'b0100 from reset -> phase 0 green for 5 ticks, yellow 3, all-red 2; phase 2 green from tick 10 (phase 1 skipped); phase 2 then rests in green.
- DEMAND=4'b0011 held -> phase 0 green 20 ticks (max-out), yellow 3, all-red 2; phase 1 green at tick 25 and also maxes out at 20.
- TICK every 4th cycle with DEMAND=4'b0010 -> all intervals scaled ×4 in cycles; no lamp change on any non-TICK cycle.
- RESET_N pulsed low during YELLOW of phase 2 -> immediately GREEN=4'b0001, timer=0, state=ST_GREEN.
- PREEMPT_EN: PREEMPT=1, PREEMPT_PHASE=3 at phase 0 green, timer=1 -> YELLOW next tick, all-red 2; phase 3 green held while PREEMPT=1 with DEMAND=4'b0111.
